// File: rtl/mimi_sram_arbiter.sv
// Arbitrates the SRAM banks between the Wishbone slave window and the CPU memory port.
// One single-cycle access is issued per clock; read data and the WB ack return one cycle later.
module mimi_sram_arbiter #(
    parameter int          NUM_BANKS = 3,
    parameter int          BANK_AW   = 9,
    parameter logic [15:0] WB_BASE   = 16'h3000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [12:0]             cpu_addr_i,
    input  logic [31:0]             cpu_wdata_i,
    input  logic [3:0]              cpu_wmask_i,
    output logic                    cpu_gnt_o,
    output logic                    cpu_rvalid_o,
    output logic [31:0]             cpu_rdata_o,
    output logic [NUM_BANKS-1:0]    sram_en_o,
    output logic [BANK_AW-1:0]      sram_addr_o,
    output logic [31:0]             sram_wdata_o,
    output logic                    sram_wen_o,
    input  logic [32*NUM_BANKS-1:0] sram_rdata_i,
    output logic                    wb_err_o
);

    typedef enum logic {
        WIN_CPU = 1'b0,
        WIN_WB  = 1'b1
    } win_t;

    win_t        last_win_reg, last_win_next;
    logic        wb_busy_reg;
    logic        wb_ack_reg;
    logic        wb_rd_reg;
    logic        cpu_rvalid_reg;
    logic [1:0]  rd_bank_reg;
    logic        err_reg, err_next;

    logic        wb_req, wb_pend, contested;
    logic        wb_win, cpu_win, issue;
    logic        sel_we;
    logic [3:0]  sel_mask;
    logic [12:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  bank;
    logic        partial_write;
    logic [31:0] bank_word [4];
    logic [31:0] rdata_sel;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[15:13];

    assign wb_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == WB_BASE);
    assign wb_pend = wb_req & ~wb_busy_reg;
    // A WB strobe still held during its ack cycle counts as contention, so the
    // CPU win in that cycle is recorded and back-to-back conflicts alternate.
    assign contested = wb_req & cpu_req_i;

    assign wb_win    = wb_pend & (~cpu_req_i | (last_win_reg == WIN_CPU));
    assign cpu_win   = cpu_req_i & ~wb_win;
    assign issue     = wb_win | cpu_win;
    assign cpu_gnt_o = cpu_win;

    always_comb begin
        sel_we    = 1'b0;
        sel_mask  = 4'h0;
        sel_addr  = 13'h0;
        sel_wdata = 32'h0;
        if (wb_win) begin
            sel_we    = wbs_we_i;
            sel_mask  = wbs_sel_i;
            sel_addr  = wbs_adr_i[12:0];
            sel_wdata = wbs_dat_i;
        end else if (cpu_win) begin
            sel_we    = cpu_we_i;
            sel_mask  = cpu_wmask_i;
            sel_addr  = cpu_addr_i;
            sel_wdata = cpu_wdata_i;
        end
    end

    assign bank          = sel_addr[12:11];
    assign partial_write = sel_we & (sel_mask != 4'hf) & (sel_mask != 4'h0);

    assign sram_addr_o  = sel_addr[BANK_AW+1:2];
    assign sram_wdata_o = sel_wdata;
    assign sram_wen_o   = issue & sel_we & (sel_mask == 4'hf);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_en
            assign sram_en_o[gi] = issue & (int'(bank) == gi);
        end
        // Bank indices beyond the populated ones read back as zero.
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            if (gi < NUM_BANKS) begin : g_pop
                assign bank_word[gi] = sram_rdata_i[32*gi +: 32];
            end else begin : g_empty
                assign bank_word[gi] = 32'h0;
            end
        end
    endgenerate

    assign rdata_sel = bank_word[rd_bank_reg];

    always_comb begin
        last_win_next = last_win_reg;
        if (contested) begin
            last_win_next = wb_win ? WIN_WB : WIN_CPU;
        end
    end

    assign err_next = err_reg | (issue & partial_write);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            last_win_reg   <= WIN_CPU;
            wb_busy_reg    <= 1'b0;
            wb_ack_reg     <= 1'b0;
            wb_rd_reg      <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            rd_bank_reg    <= 2'd0;
            err_reg        <= 1'b0;
        end else begin
            last_win_reg   <= last_win_next;
            // Busy covers exactly the ack cycle, masking the still-high strobe.
            wb_busy_reg    <= wb_win;
            wb_ack_reg     <= wb_win;
            wb_rd_reg      <= wb_win & ~wbs_we_i;
            cpu_rvalid_reg <= cpu_win & ~cpu_we_i;
            rd_bank_reg    <= bank;
            err_reg        <= err_next;
        end
    end

    assign wbs_ack_o    = wb_ack_reg;
    assign wbs_dat_o    = (wb_ack_reg & wb_rd_reg) ? rdata_sel : 32'h0;
    assign cpu_rvalid_o = cpu_rvalid_reg;
    assign cpu_rdata_o  = cpu_rvalid_reg ? rdata_sel : 32'h0;
    assign wb_err_o     = err_reg;

endmodule

// File: tb/tb_mimi_sram_arbiter.sv
// Directed bench for mimi_sram_arbiter with a behavioural 3-bank SRAM and
// a queue-based scoreboard for WB acks and CPU read returns.
module tb_mimi_sram_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_cyc, wb_stb, wb_we;
    logic [3:0]   wb_sel;
    logic [31:0]  wb_adr, wb_dat;
    logic         wb_ack;
    logic [31:0]  wb_rdat;
    logic         cpu_req, cpu_we;
    logic [12:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_wmask;
    logic         cpu_gnt, cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic [2:0]   sram_en;
    logic [8:0]   sram_addr;
    logic [31:0]  sram_wdata;
    logic         sram_wen;
    logic [95:0]  sram_rdata;
    logic         wb_err;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t         wb_q[$];
    exp_t         cpu_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cnt = 0;
    int           ack_seen = 0;

    logic [31:0]  mem [3][512];
    logic [31:0]  bank_q [3];

    always #5 clk = ~clk;

    mimi_sram_arbiter dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (wb_cyc),
        .wbs_stb_i    (wb_stb),
        .wbs_we_i     (wb_we),
        .wbs_sel_i    (wb_sel),
        .wbs_adr_i    (wb_adr),
        .wbs_dat_i    (wb_dat),
        .wbs_ack_o    (wb_ack),
        .wbs_dat_o    (wb_rdat),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_wmask_i  (cpu_wmask),
        .cpu_gnt_o    (cpu_gnt),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .sram_en_o    (sram_en),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wen_o   (sram_wen),
        .sram_rdata_i (sram_rdata),
        .wb_err_o     (wb_err)
    );

    // Behavioural single-port SRAM banks with registered read.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sram_en[k]) begin
                if (sram_wen) mem[k][sram_addr] <= sram_wdata;
                bank_q[k] <= mem[k][sram_addr];
            end
        end
    end
    assign sram_rdata = {bank_q[2], bank_q[1], bank_q[0]};

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cnt);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response.
    always @(negedge clk) begin
        if (wb_ack) begin
            ack_seen++;
            if (wb_q.size() == 0) begin
                check("wb_ack_spurious", {31'b0, wb_ack}, 32'h0);
            end else begin
                exp_t e;
                e = wb_q.pop_front();
                check("wb_dat", wb_rdat, e.data);
                check("wb_ack_cycle", cnt, e.cyc);
            end
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                check("cpu_rvalid_spurious", {31'b0, cpu_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = cpu_q.pop_front();
                check("cpu_rdata", cpu_rdata, e.data);
                check("cpu_rvalid_cycle", cnt, e.cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    endtask

    task automatic wb_idle;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
    endtask

    task automatic cpu_set(input logic we, input logic [12:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = mask;
    endtask

    task automatic cpu_idle;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
    endtask

    // Uncontested WB access: issue, held-strobe ack cycle, then release.
    task automatic wb_op(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] en_exp, input logic [8:0] a_exp,
                         input logic wen_exp, input logic [31:0] rd_exp);
        exp_t e;
        wb_set(we, adr, dat, sel);
        @(negedge clk);
        check({tag, "_en"}, {29'b0, sram_en}, {29'b0, en_exp});
        check({tag, "_addr"}, {23'b0, sram_addr}, {23'b0, a_exp});
        check({tag, "_wen"}, {31'b0, sram_wen}, {31'b0, wen_exp});
        if (we) check({tag, "_wdata"}, sram_wdata, dat);
        e.data = rd_exp; e.cyc = cnt + 1;
        wb_q.push_back(e);
        tick;
        @(negedge clk);
        check({tag, "_busy_en"}, {29'b0, sram_en}, 32'h0);
        tick;
        wb_idle;
    endtask

    task automatic cpu_op(input string tag, input logic we, input logic [12:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [2:0] en_exp, input logic [8:0] a_exp,
                          input logic wen_exp, input logic [31:0] rd_exp);
        exp_t e;
        cpu_set(we, addr, wdata, mask);
        @(negedge clk);
        check({tag, "_gnt"}, {31'b0, cpu_gnt}, 32'h1);
        check({tag, "_en"}, {29'b0, sram_en}, {29'b0, en_exp});
        check({tag, "_addr"}, {23'b0, sram_addr}, {23'b0, a_exp});
        check({tag, "_wen"}, {31'b0, sram_wen}, {31'b0, wen_exp});
        if (!we) begin
            e.data = rd_exp; e.cyc = cnt + 1;
            cpu_q.push_back(e);
        end
        tick;
        cpu_idle;
    endtask

    // One cycle of a WB-vs-CPU conflict; wb_side says who must be granted.
    task automatic conflict_cycle(input string tag, input logic wb_side, input logic [8:0] a_exp, input logic [31:0] rd_exp);
        exp_t e;
        @(negedge clk);
        check({tag, "_gnt"}, {31'b0, cpu_gnt}, {31'b0, ~wb_side});
        check({tag, "_addr"}, {23'b0, sram_addr}, {23'b0, a_exp});
        e.data = rd_exp; e.cyc = cnt + 1;
        if (wb_side) wb_q.push_back(e);
        else         cpu_q.push_back(e);
        tick;
    endtask

    initial begin
        int ack_before;
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 512; w++) mem[k][w] = 32'h0;
        for (int k = 0; k < 3; k++) bank_q[k] = 32'h0;
        mem[0][2] = 32'h1111_1111;
        mem[0][4] = 32'h2222_2222;
        mem[2][0] = 32'h1234_5678;

        wb_idle;
        cpu_idle;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, wb_ack}, 32'h0);
        check("rst_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        check("rst_err", {31'b0, wb_err}, 32'h0);
        check("rst_en", {29'b0, sram_en}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Continuous conflict from reset: WB, CPU, WB, CPU.
        wb_set(1'b0, 32'h3000_0010, 32'h0, 4'hf);
        cpu_set(1'b0, 13'h0008, 32'h0, 4'h0);
        conflict_cycle("arb0_wb", 1'b1, 9'd4, 32'h2222_2222);
        conflict_cycle("arb1_cpu", 1'b0, 9'd2, 32'h1111_1111);
        conflict_cycle("arb2_wb", 1'b1, 9'd4, 32'h2222_2222);
        conflict_cycle("arb3_cpu", 1'b0, 9'd2, 32'h1111_1111);
        wb_idle;
        cpu_idle;
        tick;

        // WB full write then read back.
        wb_op("wb_wr", 1'b1, 32'h3000_0804, 32'hDEAD_BEEF, 4'hf, 3'b010, 9'd1, 1'b1, 32'h0);
        wb_op("wb_rd", 1'b0, 32'h3000_0804, 32'h0, 4'hf, 3'b010, 9'd1, 1'b0, 32'hDEAD_BEEF);

        // CPU read of bank 2.
        cpu_op("cpu_rd", 1'b0, 13'h1000, 32'h0, 4'h0, 3'b100, 9'd0, 1'b0, 32'h1234_5678);

        // Zero-mask write: granted, no SRAM write, no error.
        cpu_op("cpu_m0", 1'b1, 13'h0004, 32'hFFFF_FFFF, 4'h0, 3'b001, 9'd1, 1'b0, 32'h0);
        @(negedge clk);
        check("m0_err", {31'b0, wb_err}, 32'h0);
        tick;

        // Partial WB write: dropped, acked, sticky error.
        wb_op("wb_part", 1'b1, 32'h3000_0008, 32'h0000_0055, 4'h3, 3'b001, 9'd2, 1'b0, 32'h0);
        check("part_err", {31'b0, wb_err}, 32'h1);
        wb_op("wb_rd_keep", 1'b0, 32'h3000_0008, 32'h0, 4'hf, 3'b001, 9'd2, 1'b0, 32'h1111_1111);
        wb_op("wb_wr_full", 1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hf, 3'b001, 9'd2, 1'b1, 32'h0);
        wb_op("wb_rd_full", 1'b0, 32'h3000_0008, 32'h0, 4'hf, 3'b001, 9'd2, 1'b0, 32'hCAFE_F00D);
        check("err_sticky", {31'b0, wb_err}, 32'h1);

        // Unpopulated bank 3 and out-of-window WB.
        cpu_op("cpu_b3", 1'b0, 13'h1800, 32'h0, 4'h0, 3'b000, 9'd0, 1'b0, 32'h0);
        tick;
        ack_before = ack_seen;
        wb_set(1'b0, 32'h2000_0000, 32'h0, 4'hf);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("oow_en", {29'b0, sram_en}, 32'h0);
            tick;
        end
        wb_idle;
        check("oow_no_ack", ack_seen, ack_before);

        // Reset in the ack cycle of a WB read drops the access.
        wb_set(1'b0, 32'h3000_0008, 32'h0, 4'hf);
        @(negedge clk);
        check("rstmid_en", {29'b0, sram_en}, 32'h1);
        tick;
        rst_n = 1'b0;
        #1;
        check("rstmid_ack", {31'b0, wb_ack}, 32'h0);
        wb_idle;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_before = ack_seen;
        repeat (3) tick;
        check("rstmid_no_ack", ack_seen, ack_before);
        check("rstmid_err", {31'b0, wb_err}, 32'h0);

        wb_set(1'b0, 32'h3000_0010, 32'h0, 4'hf);
        cpu_set(1'b0, 13'h0008, 32'h0, 4'h0);
        conflict_cycle("post_rst_wb", 1'b1, 9'd4, 32'h2222_2222);
        conflict_cycle("post_rst_cpu", 1'b0, 9'd2, 32'hCAFE_F00D);
        wb_idle;
        cpu_idle;
        tick;

        // CPU partial write also raises the error flag.
        cpu_op("cpu_part", 1'b1, 13'h0010, 32'h0000_00AA, 4'h1, 3'b001, 9'd4, 1'b0, 32'h0);
        @(negedge clk);
        check("cpu_part_err", {31'b0, wb_err}, 32'h1);
        repeat (3) tick;

        check("wb_q_drained", wb_q.size(), 32'h0);
        check("cpu_q_drained", cpu_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
